// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: 11010 preamble followed by an MSB-first payload, with
// stuff bits inserted so that 11010 can only ever appear on the line as a preamble.
module serial_pattern_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  stream_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int                CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_WIDTH);
    localparam logic [4:0]        PREAMBLE_BITS = 5'b11010;
    localparam logic [3:0]        STUFF_HIST    = 4'b1101;

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, TAIL} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              hist_q, hist_d;
    logic                    stream_q, stream_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    emit_d;

    logic stuff_now;
    logic data_bit;
    logic data_last;

    // hist_q already contains the bit currently on the line, so it decides the next one.
    assign stuff_now  = (hist_q == STUFF_HIST);
    assign data_bit   = shift_q[DATA_WIDTH-1];
    // Final data bit ends the frame unless it completes 1101 and forces a tail stuff.
    assign data_last  = !stuff_now && (cnt_q == CNT_LAST) &&
                        ({hist_q[2:0], data_bit} != STUFF_HIST);

    assign data_ready = (state_q == IDLE);
    assign stream_out = stream_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        hist_d   = hist_q;
        busy_d   = busy_q;
        stream_d = 1'b0;
        done_d   = 1'b0;
        emit_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d  = PREAMBLE;
                    idx_d    = 3'd0;
                    shift_d  = data_in;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    stream_d = PREAMBLE_BITS[4];
                    emit_d   = 1'b1;
                end
            end
            PREAMBLE: begin
                emit_d = 1'b1;
                if (idx_q == 3'd4) begin
                    state_d = PAYLOAD;
                    if (stuff_now) begin
                        stream_d = 1'b1;
                    end else begin
                        stream_d = data_bit;
                        shift_d  = shift_q << 1;
                        cnt_d    = cnt_q + CNT_W'(1);
                        done_d   = data_last;
                    end
                end else begin
                    idx_d    = idx_q + 3'd1;
                    stream_d = PREAMBLE_BITS[3'd3 - idx_q];
                end
            end
            PAYLOAD: begin
                if (cnt_q == CNT_FULL) begin
                    if (stuff_now) begin
                        state_d  = TAIL;
                        stream_d = 1'b1;
                        emit_d   = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    emit_d = 1'b1;
                    if (stuff_now) begin
                        stream_d = 1'b1;
                    end else begin
                        stream_d = data_bit;
                        shift_d  = shift_q << 1;
                        cnt_d    = cnt_q + CNT_W'(1);
                        done_d   = data_last;
                    end
                end
            end
            TAIL: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (emit_d) begin
            hist_d = {hist_q[2:0], stream_d};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            shift_q  <= '0;
            cnt_q    <= '0;
            hist_q   <= 4'b0000;
            stream_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            hist_q   <= hist_d;
            stream_q <= stream_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed and back-to-back checks for serial_pattern_tx: frame bits, stuffing,
// frame_done/busy timing, detector uniqueness and mid-frame reset.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       stream_out;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    serial_pattern_tx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .stream_out (stream_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers one word and checks every bit of the resulting frame plus the idle after it.
    task automatic send_frame(input logic [7:0] word, input logic [31:0] bits, input int len);
        data_in    = word;
        data_valid = 1'b1;
        check("ready_before", {31'd0, data_ready}, 32'd1);
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            check("bit",   {31'd0, stream_out}, {31'd0, bits[len-1-i]});
            check("busy",  {31'd0, busy},       32'd1);
            check("ready", {31'd0, data_ready}, 32'd0);
            check("done",  {31'd0, frame_done}, (i == len - 1) ? 32'd1 : 32'd0);
            tick();
        end
        check("idle_line",  {31'd0, stream_out}, 32'd0);
        check("idle_busy",  {31'd0, busy},       32'd0);
        check("idle_ready", {31'd0, data_ready}, 32'd1);
        check("idle_done",  {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] exp_w;
        logic [7:0] dword;
        logic [4:0] win;
        logic [3:0] rx_hist;
        logic       acc, b, complete, first;
        int         sent, frames, det, pulses, stuff_err, phase, dcnt, idle_run, cyc;

        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hFF;
        tick();
        tick();
        check("rst_ready",  {31'd0, data_ready}, 32'd1);
        check("rst_line",   {31'd0, stream_out}, 32'd0);
        check("rst_busy",   {31'd0, busy},       32'd0);
        check("rst_done",   {31'd0, frame_done}, 32'd0);
        reset      = 1'b0;
        data_valid = 1'b0;
        tick();
        check("post_rst_line", {31'd0, stream_out}, 32'd0);

        send_frame(8'h00, 32'b11010_00000000, 13);
        send_frame(8'hD0, 32'b11010_1101_1_0000, 14);
        send_frame(8'h0D, 32'b11010_00001101_1, 14);
        send_frame(8'hDB, 32'b11010_1101_1_101_1_1, 15);
        send_frame(8'hFF, 32'b11010_11111111, 13);

        // Back-to-back random frames, decoded by a receiver model on the line.
        sent = 0; frames = 0; det = 0; pulses = 0; stuff_err = 0;
        phase = 0; dcnt = 0; idle_run = 0; complete = 1'b0; first = 1'b1;
        win = 5'd0; rx_hist = 4'd0; dword = 8'd0;
        data_in    = 8'($urandom);
        data_valid = 1'b1;
        for (cyc = 0; cyc < 8000 && frames < 200; cyc++) begin
            acc = data_valid && data_ready;
            tick();
            if (acc) begin
                exp_q.push_back(data_in);
                sent++;
                if (sent == 200) data_valid = 1'b0;
                else             data_in    = 8'($urandom);
            end
            b   = stream_out;
            win = {win[3:0], b};
            if (win == 5'b11010) det++;
            if (frame_done) pulses++;
            case (phase)
                0: begin
                    idle_run++;
                    if (win == 5'b11010) begin
                        if (!first) check("b2b_gap", idle_run - 5, 32'd1);
                        first   = 1'b0;
                        phase   = 1;
                        rx_hist = 4'b1010;
                        dcnt    = 0;
                        dword   = 8'd0;
                    end
                end
                1: begin
                    if (rx_hist == 4'b1101) begin
                        if (b !== 1'b1) stuff_err++;
                    end else begin
                        dword = {dword[6:0], b};
                        dcnt++;
                    end
                    rx_hist = {rx_hist[2:0], b};
                    if (dcnt == 8) begin
                        if (rx_hist == 4'b1101) phase = 2;
                        else                    complete = 1'b1;
                    end
                end
                default: begin
                    if (b !== 1'b1) stuff_err++;
                    complete = 1'b1;
                end
            endcase
            if (complete) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("b2b_done",    {31'd0, frame_done}, 32'd1);
                check("b2b_payload", {24'd0, dword},      {24'd0, exp_w});
                frames++;
                phase    = 0;
                idle_run = 0;
                complete = 1'b0;
            end
        end
        check("b2b_frames",    frames,    32'd200);
        check("b2b_detects",   det,       32'd200);
        check("b2b_pulses",    pulses,    32'd200);
        check("b2b_stuff_err", stuff_err, 32'd0);
        data_valid = 1'b0;
        tick();
        tick();
        check("b2b_idle_ready", {31'd0, data_ready}, 32'd1);

        // Reset during the third payload bit of 0xA5 aborts the frame.
        data_in    = 8'hA5;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("abort_bit", {31'd0, stream_out}, 32'd1);
        reset = 1'b1;
        tick();
        check("abort_line",  {31'd0, stream_out}, 32'd0);
        check("abort_busy",  {31'd0, busy},       32'd0);
        check("abort_ready", {31'd0, data_ready}, 32'd1);
        check("abort_done",  {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        tick();
        send_frame(8'h00, 32'b11010_00000000, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial frame transmitter that drives the single-bit stream consumed by the team's 11010 pattern detector. It accepts a parallel payload word and emits a frame: the 5-bit sync preamble 11010, then the payload MSB-first. It inserts stuff bits so that 11010 appears on the line only as a preamble, which lets the detector fire exactly once per frame. It sits between the payload source and the serial link; the downstream decoder removes the stuff bits.

## Interface
- DATA_WIDTH, 8: payload bits per frame; must be ≥ 1.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- data_in  input  DATA_WIDTH  payload word, transmitted MSB first.
- data_valid  input  1  payload offer.
- data_ready  output  1  high whenever the FSM is in IDLE, including while reset is held.
- stream_out  output  1  registered serial line; 0 when idle.
- busy  output  1  registered; high from the acceptance edge through the last bit of the frame.
- frame_done  output  1  registered; one-cycle pulse coincident with the last bit of the frame.

## Operation
- Acceptance: a word is accepted on a rising edge where data_valid && data_ready && !reset. data_in is captured into a shift register; it is not sampled again during the frame. data_valid is ignored outside IDLE and while reset is high.
- FSM states:
  - IDLE → PREAMBLE on acceptance.
  - PREAMBLE: emits 1,1,0,1,0 using a 3-bit index; then → PAYLOAD.
  - PAYLOAD: emits DATA_WIDTH data bits, interleaved with stuff bits; then → TAIL if a tail stuff is needed, else → IDLE.
  - TAIL: emits one stuff bit, then → IDLE.
- History register hist[3:0] holds the last 4 bits emitted on stream_out, newest in bit 0.
  - Every emitted bit updates it, including preamble, data and stuff bits.
  - It is cleared to 0000 on reset.
  - It is not cleared between frames.
- Stuff rule in PAYLOAD: before emitting the next data bit, if hist == 4'b1101, emit a 1 instead and hold the data bit and the bit counter. This check repeats before every data bit.
- Tail rule: after the final data bit, if hist == 4'b1101, emit one stuff 1 in TAIL before going idle. This prevents an idle 0 from completing 11010.
- No stuffing occurs in PREAMBLE.
- Guarantee: no suffix of a payload/tail joined with a prefix of 11010 forms 11010. Therefore 11010 occurs on the line only as a preamble, including with back-to-back frames.
- Frame length is 5 + DATA_WIDTH + S bits, where S is the number of stuff bits (payload plus tail).
- The bit counter is sized ceil(log2(DATA_WIDTH+1)). It counts only data bits.

## Timing
- Reset values:
  - stream_out = 0, busy = 0, frame_done = 0.
  - FSM in IDLE, hist = 0000.
  - data_ready = 1 once the FSM is in IDLE.
- Reset mid-frame aborts on that edge with the values above; the partial frame is lost. Both ends of the link share reset.
- Latency: for acceptance at edge T, the first preamble bit is on stream_out during cycle T+1 and busy rises at edge T. Each bit is held exactly one cycle.
- Last bit during cycle T+L, where L is the frame length. frame_done = 1 in that cycle only.
- At edge T+L: stream_out → 0, busy → 0, data_ready → 1.
- Back-to-back: with data_valid held high, the next acceptance is at edge T+L+1. This gives exactly one idle 0 between frames.
- The data_ready → data_valid path is combinational only from state. There is no combinational path from data_valid to data_ready.

## Test plan
- Reset, then DATA_WIDTH=8, data_in=0x00 → stream 11010 00000000, 13 bits; frame_done in the 13th bit cycle; busy high for 13 cycles; stream_out=0 afterwards.
- data_in=0xD0 → 11010 1101 1 0000, 14 bits: stuff after the 4th data bit.
- data_in=0x0D → 11010 00001101 1, 14 bits: tail stuff, then idle 0.
- data_in=0xDB → 11010 1101 1 101 1 1, 15 bits: two payload stuffs, no tail. data_in=0xFF → 13 bits, no stuffs.
- Back-to-back, 200 random words with data_valid held high → a detector model on stream_out fires exactly once per frame, at each preamble end. Gap between frames is exactly 1 zero bit. Decoded payloads match the inputs.
- Assert reset in the 3rd payload bit of 0xA5 → the next cycle has stream_out=0, busy=0 and data_ready=1, with no frame_done pulse. A fresh 0x00 frame then transmits correctly with hist starting at 0000.
